// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit sides.
package uart_pkg;

   localparam int unsigned TICKS_PER_BIT_DEFAULT = 16;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StData  = 2'd2,
      StStop  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is always visible on o_dout.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_din,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dout,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign o_full  = (count_q == (AW+1)'(DEPTH));
   assign o_empty = (count_q == '0);
   assign o_count = count_q;
   assign o_dout  = mem_q[rd_ptr_q];

   // Guarded here so the FIFO is safe on its own, whatever the caller does.
   assign do_push = i_push && !o_full;
   assign do_pop  = i_pop && !o_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wr_ptr_q] <= i_din;
   end

endmodule

// File: rtl/uart_trans.sv
// UART transmitter: byte FIFO feeding an 8N1 framer clocked by a 16x baud tick.
module uart_trans
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH    = 8,
   parameter int unsigned TICKS_PER_BIT = TICKS_PER_BIT_DEFAULT
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clken,
   input  logic [7:0] i_din_8b,
   input  logic       i_din_valid,
   output logic       o_din_ready,
   output logic       o_tx,
   output logic       o_busy
);

   localparam int unsigned TW = $clog2(TICKS_PER_BIT);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   uart_state_e     state_q;
   logic [TW-1:0]   tick_q;
   logic [2:0]      bit_q;
   logic [7:0]      shift_q;
   logic            tx_q;

   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_pop;
   logic [7:0]      fifo_dout;
   logic [CW-1:0]   fifo_count;
   logic            tick_last;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (i_din_valid && o_din_ready),
      .i_din   (i_din_8b),
      .i_pop   (fifo_pop),
      .o_dout  (fifo_dout),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (fifo_count)
   );

   assign tick_last = i_clken && (tick_q == TW'(TICKS_PER_BIT - 1));

   // Stop-bit pop lets the next start bit follow with no idle gap.
   assign fifo_pop = !fifo_empty &&
                     ((state_q == StIdle) || ((state_q == StStop) && tick_last));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               tx_q <= 1'b1;
               if (!fifo_empty) begin
                  shift_q <= fifo_dout;
                  tick_q  <= '0;
                  bit_q   <= '0;
                  state_q <= StStart;
                  tx_q    <= 1'b0;
               end
            end
            StStart: begin
               if (tick_last) begin
                  tick_q  <= '0;
                  bit_q   <= '0;
                  state_q <= StData;
                  tx_q    <= shift_q[0];
               end else if (i_clken) begin
                  tick_q <= tick_q + 1'b1;
               end
            end
            StData: begin
               if (tick_last) begin
                  tick_q <= '0;
                  if (bit_q == 3'd7) begin
                     state_q <= StStop;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                     tx_q  <= shift_q[bit_q + 3'd1];
                  end
               end else if (i_clken) begin
                  tick_q <= tick_q + 1'b1;
               end
            end
            StStop: begin
               if (tick_last) begin
                  tick_q <= '0;
                  if (!fifo_empty) begin
                     shift_q <= fifo_dout;
                     bit_q   <= '0;
                     state_q <= StStart;
                     tx_q    <= 1'b0;
                  end else begin
                     state_q <= StIdle;
                  end
               end else if (i_clken) begin
                  tick_q <= tick_q + 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               tick_q  <= '0;
               bit_q   <= '0;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   assign o_tx        = tx_q;
   assign o_din_ready = !fifo_full;
   assign o_busy      = (state_q != StIdle) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_trans.sv
// Self-checking bench for uart_trans: vector table, serial-line decoder and random bursts.
module tb_uart_trans;

   localparam int unsigned TPB   = 16;
   localparam int unsigned DEPTH = 8;

   logic       i_clk;
   logic       i_rst_n;
   logic       i_clken;
   logic [7:0] i_din_8b;
   logic       i_din_valid;
   logic       o_din_ready;
   logic       o_tx;
   logic       o_busy;

   int errors  = 0;
   int checks  = 0;
   int div     = 1;
   int bit_cyc = TPB;
   int phase   = 0;
   logic [8:0] rx_q[$];

   typedef struct {
      logic [7:0] din;
      logic [9:0] frame;   // frame[0] = start bit, frame[9] = stop bit
   } vec_t;

   uart_trans #(
      .FIFO_DEPTH    (DEPTH),
      .TICKS_PER_BIT (TPB)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_clken     (i_clken),
      .i_din_8b    (i_din_8b),
      .i_din_valid (i_din_valid),
      .o_din_ready (o_din_ready),
      .o_tx        (o_tx),
      .o_busy      (o_busy)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Baud tick: high one cycle in every div; changes on the falling edge.
   initial begin
      i_clken = 1'b1;
      forever begin
         @(negedge i_clk);
         phase++;
         if (phase >= div) phase = 0;
         i_clken = (phase == 0);
      end
   end

   // Reference receiver: mid-bit sampling of the line, pushes {stop, data}.
   initial begin : decoder
      logic [7:0] d;
      logic       sb;
      int         bc;
      forever begin
         @(posedge i_clk);
         #1;
         if (i_rst_n === 1'b1 && o_tx === 1'b0) begin
            bc = bit_cyc;
            repeat (bc / 2) @(posedge i_clk);
            for (int k = 0; k < 8; k++) begin
               repeat (bc) @(posedge i_clk);
               #1;
               d[k] = o_tx;
            end
            repeat (bc) @(posedge i_clk);
            #1;
            sb = o_tx;
            rx_q.push_back({sb, d});
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) step();
   endtask

   task automatic set_div(input int d);
      div     = d;
      bit_cyc = TPB * d;
      wait_cycles(2 * d + 2);
   endtask

   task automatic push_byte(input logic [7:0] b);
      i_din_8b    = b;
      i_din_valid = 1'b1;
      step();
      i_din_valid = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int budget);
      int c = 0;
      while (rx_q.size() < n && c < budget) begin
         step();
         c++;
      end
      check("rx_count", rx_q.size(), n);
   endtask

   function automatic logic [8:0] pop_rx();
      if (rx_q.size() == 0) return 9'h000;
      return rx_q.pop_front();
   endfunction

   initial begin : main
      vec_t       vecs[7];
      logic [7:0] exp_q[$];
      logic [9:0] fr;
      int         bad;

      vecs[0] = '{8'h55, 10'b1_01010101_0};
      vecs[1] = '{8'h00, 10'b1_00000000_0};
      vecs[2] = '{8'hFF, 10'b1_11111111_0};
      vecs[3] = '{8'hA5, 10'b1_10100101_0};
      vecs[4] = '{8'h3C, 10'b1_00111100_0};
      vecs[5] = '{8'h01, 10'b1_00000001_0};
      vecs[6] = '{8'h80, 10'b1_10000000_0};

      i_rst_n     = 1'b0;
      i_din_valid = 1'b0;
      i_din_8b    = 8'h00;
      repeat (3) @(posedge i_clk);
      #1;
      check("reset_tx", o_tx, 1);
      check("reset_busy", o_busy, 0);
      check("reset_ready", o_din_ready, 1);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      wait_cycles(4);
      check("post_reset_tx", o_tx, 1);
      check("post_reset_busy", o_busy, 0);

      // Single frames with the tick held high: every cycle of every bit checked.
      for (int v = 0; v < 7; v++) begin
         rx_q.delete();
         check("table_ready", o_din_ready, 1);
         push_byte(vecs[v].din);
         check("table_tx_before_start", o_tx, 1);
         check("table_busy_queued", o_busy, 1);
         fr = vecs[v].frame;
         for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int c = 0; c < TPB; c++) begin
               step();
               if (o_tx !== fr[k]) bad++;
            end
            check($sformatf("table%0d_bit%0d_bad_cycles", v, k), bad, 0);
         end
         check("table_busy_last_cycle", o_busy, 1);
         step();
         check("table_busy_fall", o_busy, 0);
         check("table_tx_idle", o_tx, 1);
         check($sformatf("table%0d_rx", v), pop_rx(), {1'b1, vecs[v].din});
      end

      // Three pushes in consecutive cycles: frames must abut with no idle bits.
      begin
         int t = 0;
         int t_low = -1;
         int t_end = -1;
         int highs = 0;
         rx_q.delete();
         while (t_end < 0 && t < 700) begin
            i_din_valid = (t < 3);
            i_din_8b    = 8'h00;
            step();
            t++;
            if (t_low < 0 && o_tx === 1'b0) t_low = t;
            if (t_low >= 0) begin
               if (o_busy === 1'b0) t_end = t;
               else if (o_tx === 1'b1) highs++;
            end
         end
         i_din_valid = 1'b0;
         check("b2b_total_cycles", t_end - t_low, 3 * 10 * TPB);
         check("b2b_high_cycles", highs, 3 * TPB);
         check("b2b_rx_count", rx_q.size(), 3);
         for (int j = 0; j < 3; j++) check("b2b_rx", pop_rx(), 9'h100);
      end

      // Valid held for 12 cycles from idle: model of occupancy decides acceptance.
      begin
         int   occ = 0;
         bit   started = 1'b0;
         bit   exp_ready;
         bit   pop;
         rx_q.delete();
         exp_q.delete();
         for (int c = 0; c < 12; c++) begin
            i_din_8b    = 8'h10 + 8'(c);
            i_din_valid = 1'b1;
            exp_ready   = (occ < DEPTH);
            check($sformatf("burst_ready_c%0d", c), o_din_ready, exp_ready);
            if (exp_ready) exp_q.push_back(i_din_8b);
            pop = (occ > 0) && !started;
            occ = occ + int'(exp_ready) - int'(pop);
            if (pop) started = 1'b1;
            step();
         end
         i_din_valid = 1'b0;
         check("burst_accepted", exp_q.size(), DEPTH + 1);
         wait_rx(exp_q.size(), exp_q.size() * 10 * TPB + 200);
         foreach (exp_q[j]) check($sformatf("burst_rx%0d", j), pop_rx(), {1'b1, exp_q[j]});
         wait_cycles(3 * TPB);
         check("burst_no_extra", rx_q.size(), 0);
         check("burst_busy_done", o_busy, 0);
      end

      // Tick every 4th cycle: data bits last 64 cycles, line moves only on ticks.
      begin
         int chg[16];
         int nchg = 0;
         int untick = 0;
         int badlen = 0;
         logic prev;
         set_div(4);
         rx_q.delete();
         push_byte(8'h55);
         prev = o_tx;
         for (int c = 0; c < 700; c++) begin
            step();
            if (o_tx !== prev) begin
               if (nchg > 0 && i_clken !== 1'b1) untick++;
               if (nchg < 16) chg[nchg] = c;
               nchg++;
            end
            prev = o_tx;
         end
         check("div4_changes", nchg, 10);
         check("div4_untick_changes", untick, 0);
         for (int k = 1; k < 9; k++) if (chg[k+1] - chg[k] != 4 * TPB) badlen++;
         check("div4_bad_bit_lengths", badlen, 0);
         check("div4_rx", pop_rx(), 9'h155);
         check("div4_busy_done", o_busy, 0);
      end

      // Reset mid-frame during bit 3 of 0xC3 with four bytes queued behind it.
      begin
         logic [7:0] q5[5];
         q5[0] = 8'hC3; q5[1] = 8'h11; q5[2] = 8'h22; q5[3] = 8'h33; q5[4] = 8'h44;
         set_div(1);
         rx_q.delete();
         i_din_valid = 1'b1;
         for (int j = 0; j < 5; j++) begin
            i_din_8b = q5[j];
            step();
         end
         i_din_valid = 1'b0;
         wait_cycles(67);
         check("rst_tx_in_bit3", o_tx, 0);
         #2;
         i_rst_n = 1'b0;
         #1;
         check("rst_async_tx", o_tx, 1);
         check("rst_async_busy", o_busy, 0);
         check("rst_async_ready", o_din_ready, 1);
         repeat (3) @(posedge i_clk);
         @(negedge i_clk);
         i_rst_n = 1'b1;
         bad = 0;
         for (int c = 0; c < 300; c++) begin
            step();
            if (o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
         end
         check("rst_line_stays_idle", bad, 0);
         rx_q.delete();
         push_byte(8'h5A);
         wait_rx(1, 20 * TPB);
         check("rst_new_byte_rx", pop_rx(), 9'h15A);
      end

      // Random bursts at random tick rates against a queue of pushed bytes.
      for (int it = 0; it < 6; it++) begin
         int n;
         logic [7:0] b;
         set_div(int'($urandom_range(1, 3)));
         rx_q.delete();
         exp_q.delete();
         n = int'($urandom_range(1, 6));
         for (int j = 0; j < n; j++) begin
            b = 8'($urandom);
            check("rand_ready", o_din_ready, 1);
            push_byte(b);
            exp_q.push_back(b);
            wait_cycles(int'($urandom_range(0, 2)));
         end
         wait_rx(n, n * 10 * bit_cyc + 4 * bit_cyc);
         foreach (exp_q[j]) check($sformatf("rand%0d_rx%0d", it, j), pop_rx(), {1'b1, exp_q[j]});
         wait_cycles(bit_cyc);
         check("rand_busy_done", o_busy, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_trans.md
UART_TRANS -- requirements
Module: uart_trans

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of bytes buffered ahead of the shifter; power of two, minimum 2.
REQ-002 Parameter TICKS_PER_BIT, default 16, number of i_clken ticks per bit period; matches the 16x oversample of the receive side.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_clken  input  1  baud tick, one i_clk cycle wide, same tick source as the receiver (16x baud).
REQ-006 i_din_8b  input  8  byte to transmit.
REQ-007 i_din_valid  input  1  byte on i_din_8b is offered this cycle.
REQ-008 o_din_ready  output  1  FIFO can accept a byte this cycle.
REQ-009 o_tx  output  1  serial line; idle high; registered.
REQ-010 o_busy  output  1  high while a frame is in flight or the FIFO is non-empty.

Function
REQ-011 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity; each bit lasts exactly TICKS_PER_BIT i_clken ticks.
REQ-012 A byte SHALL be written into the FIFO on every i_clk edge where i_din_valid && o_din_ready; i_clken does not gate writes.
REQ-013 o_din_ready SHALL equal !full, computed from the current occupancy only; a pop in the same cycle does not raise ready while full.
REQ-014 When i_din_valid is high while o_din_ready is low, the byte SHALL be dropped with no state change.
REQ-015 State machine states SHALL be IDLE, START, DATA and STOP.
REQ-016 IDLE: o_tx=1; on any i_clk cycle with the FIFO non-empty, pop the head into the shift register, clear the tick and bit counters, and enter START; o_tx goes low on the next cycle.
REQ-017 START: o_tx=0; count i_clken ticks; on tick TICKS_PER_BIT-1, clear the tick counter and enter DATA with bit index 0.
REQ-018 DATA: o_tx=shift[bit index]; on tick TICKS_PER_BIT-1, clear the tick counter and increment the bit index; after index 7 completes, enter STOP.
REQ-019 STOP: o_tx=1; on tick TICKS_PER_BIT-1, if the FIFO is non-empty, pop and enter START in the same cycle (back-to-back, no idle bit); otherwise enter IDLE.
REQ-020 The tick counter width SHALL be $clog2(TICKS_PER_BIT); the bit index SHALL be 3 bits; FIFO pointers SHALL wrap modulo FIFO_DEPTH, and occupancy SHALL be $clog2(FIFO_DEPTH)+1 bits.
REQ-021 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged; a push into an empty FIFO SHALL be poppable no earlier than the following cycle.
REQ-022 Cycles without i_clken SHALL hold all counters, and o_tx SHALL hold its level.
REQ-023 o_busy SHALL be (state != IDLE) || (occupancy != 0), registered-equivalent, with no combinational path from i_din_valid.
REQ-024 An illegal state encoding SHALL return to IDLE on the next cycle with o_tx=1.

Reset
REQ-025 While i_rst_n is low: o_tx=1, o_busy=0, o_din_ready=1 (FIFO empty), state=IDLE, and all counters and pointers are 0.
REQ-026 Reset asserted mid-frame SHALL drive o_tx high immediately (asynchronously) and discard the in-flight byte and all FIFO contents.

Structure
REQ-027 State encodings (IDLE/START/DATA/STOP) and the default TICKS_PER_BIT SHALL live in the shared UART package used by both the receive and transmit sides.
REQ-028 The FIFO SHALL be one sub-module, uart_tx_fifo (synchronous, first-word-fall-through, parameterised depth/width, full/empty/count outputs); all framing logic stays in uart_trans.

Verification
REQ-029 i_clken tied high, push 0x55 once -> o_tx low for 16 cycles, then 1,0,1,0,1,0,1,0 for 16 cycles each, then high for 16 cycles; o_busy falls after 160 cycles of frame.
REQ-030 Loopback: o_tx feeds the receiver; push 0x00, 0xFF, 0xA5, 0x3C -> the receiver emits the same four bytes in order, each with a one-cycle o_dout_valid.
REQ-031 Push 3 bytes in consecutive cycles -> the stop bit of byte N is followed directly by the start bit of byte N+1, with no extra high ticks (total 480 ticks).
REQ-032 Hold i_din_valid high for 12 cycles while idle, FIFO_DEPTH=8 -> 8 bytes are accepted (the first is popped, so 9 are accepted in total), o_din_ready falls, extra bytes are dropped, and exactly the accepted bytes are transmitted.
REQ-033 i_clken pulsed every 4th cycle -> each bit lasts 64 i_clk cycles; o_tx never changes on a cycle without a preceding tick.
REQ-034 Assert i_rst_n low during bit 3 of 0xC3 with 4 bytes queued -> o_tx=1 within the same cycle, o_busy=0, o_din_ready=1; after release the line stays idle until a new push occurs.
